// File: rtl/cp0_ext_pkg.sv
// Shared CP0 definitions: register numbers, exception codes and status/cause field positions.
package cp0_ext_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned EXC_W = 5;
    localparam int unsigned REG_W = 5;

    localparam logic [REG_W-1:0] CP0_BADVADDR = 5'd8;
    localparam logic [REG_W-1:0] CP0_COUNT    = 5'd9;
    localparam logic [REG_W-1:0] CP0_COMPARE  = 5'd11;
    localparam logic [REG_W-1:0] CP0_SR       = 5'd12;
    localparam logic [REG_W-1:0] CP0_CAUSE    = 5'd13;
    localparam logic [REG_W-1:0] CP0_EPC      = 5'd14;
    localparam logic [REG_W-1:0] CP0_PRID     = 5'd15;

    localparam logic [EXC_W-1:0] EXC_INT     = 5'd0;
    localparam logic [EXC_W-1:0] EXC_ADEL    = 5'd4;
    localparam logic [EXC_W-1:0] EXC_ADES    = 5'd5;
    localparam logic [EXC_W-1:0] EXC_SYSCALL = 5'd8;
    localparam logic [EXC_W-1:0] EXC_RI      = 5'd10;
    localparam logic [EXC_W-1:0] EXC_OV      = 5'd12;

    localparam int unsigned IE_BIT  = 0;
    localparam int unsigned EXL_BIT = 1;
    localparam int unsigned EXC_LO  = 2;
    localparam int unsigned IM_LO   = 10;
    localparam int unsigned BD_BIT  = 31;

    // Address-error exceptions are the only ones that capture BadVAddr.
    function automatic logic is_addr_exc(input logic [EXC_W-1:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer with prescaler and a latched compare-match pending bit.
module cp0_timer
    import cp0_ext_pkg::*;
#(
    parameter int unsigned COUNT_DIV = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we_count,
    input  logic            we_compare,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] count,
    output logic [XLEN-1:0] compare,
    output logic            pend
);

    localparam int unsigned PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

    logic [PW-1:0]   presc;
    logic            tick;
    logic [XLEN-1:0] count_inc;
    logic            hit;

    assign tick      = (presc == PW'(COUNT_DIV - 1));
    assign count_inc = count + 32'd1;
    // A software load of Count suppresses the increment, so it can never raise a match.
    assign hit       = tick & ~we_count & (count_inc == compare);

    always_ff @(posedge clk) begin
        if (reset) begin
            presc   <= '0;
            count   <= '0;
            compare <= '0;
            pend    <= 1'b0;
        end else begin
            if (we_count || tick) begin
                presc <= '0;
            end else begin
                presc <= presc + PW'(1);
            end

            if (we_count) begin
                count <= wdata;
            end else if (tick) begin
                count <= count_inc;
            end

            if (we_compare) begin
                compare <= wdata;
            end

            // Compare write acknowledges the interrupt and wins over a coincident match.
            if (we_compare) begin
                pend <= 1'b0;
            end else if (hit) begin
                pend <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_ext.sv
// CP0 beside the M stage: SR/Cause/EPC/BadVAddr, trap arbitration, mfc0 read mux and timer.
module cp0_ext
    import cp0_ext_pkg::*;
#(
    parameter int unsigned NUM_HWINT  = 6,
    parameter int unsigned TIMER_LINE = 5,
    parameter int unsigned COUNT_DIV  = 1,
    parameter logic [31:0] PRID_VAL   = 32'h0000_7C01
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [EXC_W-1:0]     exc_code,
    input  logic [XLEN-1:0]      vpc,
    input  logic                 bd,
    input  logic [XLEN-1:0]      bad_vaddr,
    input  logic [NUM_HWINT-1:0] hw_int,
    input  logic                 eret,
    input  logic                 we,
    input  logic [REG_W-1:0]     addr,
    input  logic [XLEN-1:0]      wdata,
    output logic [XLEN-1:0]      rdata,
    output logic                 req,
    output logic [XLEN-1:0]      epc_out,
    output logic                 timer_irq
);

    logic [XLEN-1:0]      sr;
    logic [XLEN-1:0]      sr_next;
    logic [XLEN-1:0]      epc;
    logic [XLEN-1:0]      bva;
    logic                 cause_bd;
    logic [EXC_W-1:0]     cause_exc;
    logic [NUM_HWINT-1:0] cause_ip;
    logic [XLEN-1:0]      cause_val;

    logic [NUM_HWINT-1:0] irq_vec;
    logic                 timer_pend;
    logic                 int_req;
    logic                 exc_req;
    logic                 wr;
    logic [XLEN-1:0]      count;
    logic [XLEN-1:0]      compare;
    logic [XLEN-1:0]      trap_pc;

    assign irq_vec = hw_int | (NUM_HWINT'(timer_pend) << TIMER_LINE);
    assign int_req = sr[IE_BIT] & (|(sr[IM_LO +: NUM_HWINT] & irq_vec)) & ~sr[EXL_BIT];
    assign exc_req = (exc_code != EXC_INT) & ~sr[EXL_BIT];
    assign req     = int_req | exc_req;
    assign wr      = we & ~req;
    assign trap_pc = bd ? (vpc - 32'd4) : vpc;

    cp0_timer #(
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .we_count   (wr && (addr == CP0_COUNT)),
        .we_compare (wr && (addr == CP0_COMPARE)),
        .wdata      (wdata),
        .count      (count),
        .compare    (compare),
        .pend       (timer_pend)
    );

    assign timer_irq = timer_pend;

    // A trap wins over both the mtc0 and a coincident eret.
    always_comb begin
        sr_next = sr;
        if (req) begin
            sr_next[EXL_BIT] = 1'b1;
        end else begin
            if (wr && (addr == CP0_SR)) begin
                sr_next = wdata;
            end
            if (eret) begin
                sr_next[EXL_BIT] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr        <= '0;
            epc       <= '0;
            bva       <= '0;
            cause_bd  <= 1'b0;
            cause_exc <= '0;
            cause_ip  <= '0;
        end else begin
            sr       <= sr_next;
            cause_ip <= irq_vec;
            if (req) begin
                cause_bd  <= bd;
                cause_exc <= int_req ? EXC_INT : exc_code;
                epc       <= trap_pc;
                if (!int_req && is_addr_exc(exc_code)) begin
                    bva <= bad_vaddr;
                end
            end else if (wr && (addr == CP0_EPC)) begin
                epc <= wdata;
            end
        end
    end

    always_comb begin
        cause_val                      = '0;
        cause_val[BD_BIT]              = cause_bd;
        cause_val[EXC_LO +: EXC_W]     = cause_exc;
        cause_val[IM_LO +: NUM_HWINT]  = cause_ip;
    end

    always_comb begin
        rdata = '0;
        case (addr)
            CP0_BADVADDR: rdata = bva;
            CP0_COUNT:    rdata = count;
            CP0_COMPARE:  rdata = compare;
            CP0_SR:       rdata = sr;
            CP0_CAUSE:    rdata = cause_val;
            CP0_EPC:      rdata = epc;
            CP0_PRID:     rdata = PRID_VAL;
            default:      rdata = '0;
        endcase
    end

    // ERET in the same cycle as an EPC mtc0 must see the new value.
    assign epc_out = (wr && (addr == CP0_EPC)) ? wdata : epc;

endmodule
